multicycle_maindec: RTL and testbench



---
 rtl/legv8_ctrl_pkg.sv | 70 +++++++
 rtl/op_class_dec.sv | 36 +++
 rtl/multicycle_maindec.sv | 233 +++++++++++++++++++++++
 tb/tb_multicycle_maindec.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_ctrl_pkg.sv
// Shared LEGv8 control definitions: FSM state codes, instruction classes,
// opcode match patterns and datapath select encodings.
package legv8_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADDR  = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXEC_R   = 4'd6,
        ST_EXEC_I   = 4'd7,
        ST_ALUWB    = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JUMP     = 4'd10,
        ST_ERROR    = 4'd11
    } state_e;

    typedef enum logic [2:0] {
        CLS_ILLEGAL = 3'd0,
        CLS_LDUR    = 3'd1,
        CLS_STUR    = 3'd2,
        CLS_RTYPE   = 3'd3,
        CLS_ITYPE   = 3'd4,
        CLS_CBZ     = 3'd5,
        CLS_CBNZ    = 3'd6,
        CLS_B       = 3'd7
    } instr_class_e;

    // Opcode patterns as value/mask pairs; mask bits at 0 are don't-care.
    localparam logic [10:0] MASK_FULL = 11'b111_1111_1111;
    localparam logic [10:0] MASK_CB   = 11'b111_1111_1000;
    localparam logic [10:0] MASK_B    = 11'b111_1110_0000;
    localparam logic [10:0] MASK_IMM  = 11'b111_1111_1110;

    localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
    localparam logic [10:0] OP_STUR = 11'b111_1100_0000;
    localparam logic [10:0] OP_CBZ  = 11'b101_1010_0000;
    localparam logic [10:0] OP_CBNZ = 11'b101_1010_1000;
    localparam logic [10:0] OP_B    = 11'b000_1010_0000;
    localparam logic [10:0] OP_ADD  = 11'b100_0101_1000;
    localparam logic [10:0] OP_SUB  = 11'b110_0101_1000;
    localparam logic [10:0] OP_AND  = 11'b100_0101_0000;
    localparam logic [10:0] OP_ORR  = 11'b101_0101_0000;
    localparam logic [10:0] OP_ADDI = 11'b100_1000_1000;
    localparam logic [10:0] OP_SUBI = 11'b110_1000_1000;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BROFF = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    function automatic logic op_match(input logic [10:0] op,
                                      input logic [10:0] value,
                                      input logic [10:0] mask);
        return ((op & mask) == (value & mask));
    endfunction

    // States that talk to memory and therefore wait for ready.
    function automatic logic is_mem_state(input state_e s);
        return (s == ST_FETCH) || (s == ST_MEMREAD) || (s == ST_MEMWRITE);
    endfunction

endpackage

// File: rtl/op_class_dec.sv
// Combinational LEGv8 opcode classifier, shared by the single- and
// multicycle control paths.
module op_class_dec
    import legv8_ctrl_pkg::*;
#(
    parameter bit HAS_IMM = 1'b1
)(
    input  logic [10:0]  Op,
    output instr_class_e op_class
);

    // Priority-free decode: the patterns are mutually exclusive.
    always_comb begin
        op_class = CLS_ILLEGAL;
        if (op_match(Op, OP_LDUR, MASK_FULL)) begin
            op_class = CLS_LDUR;
        end else if (op_match(Op, OP_STUR, MASK_FULL)) begin
            op_class = CLS_STUR;
        end else if (op_match(Op, OP_CBZ, MASK_CB)) begin
            op_class = CLS_CBZ;
        end else if (op_match(Op, OP_CBNZ, MASK_CB)) begin
            op_class = CLS_CBNZ;
        end else if (op_match(Op, OP_B, MASK_B)) begin
            op_class = CLS_B;
        end else if (op_match(Op, OP_ADD, MASK_FULL) || op_match(Op, OP_SUB, MASK_FULL) ||
                     op_match(Op, OP_AND, MASK_FULL) || op_match(Op, OP_ORR, MASK_FULL)) begin
            op_class = CLS_RTYPE;
        end else if (HAS_IMM && (op_match(Op, OP_ADDI, MASK_IMM) ||
                                 op_match(Op, OP_SUBI, MASK_IMM))) begin
            op_class = CLS_ITYPE;
        end else begin
            op_class = CLS_ILLEGAL;
        end
    end

endmodule

// File: rtl/multicycle_maindec.sv
// Multicycle LEGv8 control FSM for a shared-memory datapath, with memory
// ready handshake, optional wait timeout and illegal-opcode reporting.
module multicycle_maindec
    import legv8_ctrl_pkg::*;
#(
    parameter bit          HAS_IMM       = 1'b1,
    parameter bit          MEM_HANDSHAKE = 1'b1,
    parameter int unsigned MEM_TIMEOUT   = 32'd0
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] Op,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        Reg2Loc,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        IorD,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic        PCSrc,
    output logic        illegal_op,
    output logic        mem_err,
    output logic [3:0]  state_o
);

    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

    state_e       state_r;
    state_e       state_nxt_s;
    logic [7:0]   wait_cnt_r;
    logic         mem_err_r;
    logic         ready_s;
    logic         timeout_s;
    instr_class_e cls_s;
    logic         reg_write_s;
    logic         mem_write_s;
    logic         ir_write_s;
    logic         pc_write_s;
    logic         illegal_s;

    op_class_dec #(.HAS_IMM(HAS_IMM)) u_op_class_dec (
        .Op       (Op),
        .op_class (cls_s)
    );

    // Effective memory ready after applying the handshake option.
    always_comb begin
        if (MEM_HANDSHAKE) begin
            ready_s = mem_ready;
        end else begin
            ready_s = 1'b1;
        end
    end

    // Only meaningful in memory states; ready wins over timeout.
    assign timeout_s = (TIMEOUT_C != 8'd0) && !ready_s && (wait_cnt_r == TIMEOUT_C);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Wait counter: restarts on any state change, counts not-ready cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_r <= 8'd0;
        end else if (state_nxt_s != state_r) begin
            wait_cnt_r <= 8'd0;
        end else if (is_mem_state(state_r) && !ready_s && (wait_cnt_r != 8'hFF)) begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Sticky memory timeout flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_err_r <= 1'b0;
        end else if (state_nxt_s == ST_ERROR) begin
            mem_err_r <= 1'b1;
        end else begin
            mem_err_r <= mem_err_r;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_FETCH: begin
                if (ready_s)        state_nxt_s = ST_DECODE;
                else if (timeout_s) state_nxt_s = ST_ERROR;
                else                state_nxt_s = ST_FETCH;
            end
            ST_DECODE: begin
                case (cls_s)
                    CLS_LDUR, CLS_STUR: state_nxt_s = ST_MEMADDR;
                    CLS_RTYPE:          state_nxt_s = ST_EXEC_R;
                    CLS_ITYPE:          state_nxt_s = ST_EXEC_I;
                    CLS_CBZ, CLS_CBNZ:  state_nxt_s = ST_BRANCH;
                    CLS_B:              state_nxt_s = ST_JUMP;
                    default:            state_nxt_s = ST_FETCH;
                endcase
            end
            ST_MEMADDR: begin
                if (cls_s == CLS_STUR) state_nxt_s = ST_MEMWRITE;
                else                   state_nxt_s = ST_MEMREAD;
            end
            ST_MEMREAD: begin
                if (ready_s)        state_nxt_s = ST_MEMWB;
                else if (timeout_s) state_nxt_s = ST_ERROR;
                else                state_nxt_s = ST_MEMREAD;
            end
            ST_MEMWRITE: begin
                if (ready_s)        state_nxt_s = ST_FETCH;
                else if (timeout_s) state_nxt_s = ST_ERROR;
                else                state_nxt_s = ST_MEMWRITE;
            end
            ST_MEMWB:   state_nxt_s = ST_FETCH;
            ST_EXEC_R:  state_nxt_s = ST_ALUWB;
            ST_EXEC_I:  state_nxt_s = ST_ALUWB;
            ST_ALUWB:   state_nxt_s = ST_FETCH;
            ST_BRANCH:  state_nxt_s = ST_FETCH;
            ST_JUMP:    state_nxt_s = ST_FETCH;
            ST_ERROR:   state_nxt_s = ST_ERROR;
            default:    state_nxt_s = ST_FETCH;
        endcase
    end

    // Output decode per state; anything not set here stays 0.
    always_comb begin
        Reg2Loc     = 1'b0;
        MemtoReg    = 1'b0;
        reg_write_s = 1'b0;
        MemRead     = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        pc_write_s  = 1'b0;
        IorD        = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        ALUOp       = ALUOP_ADD;
        PCSrc       = 1'b0;
        illegal_s   = 1'b0;
        case (state_r)
            ST_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                if (ready_s) begin
                    ir_write_s = 1'b1;
                    pc_write_s = 1'b1;
                end else begin
                    ir_write_s = 1'b0;
                    pc_write_s = 1'b0;
                end
            end
            ST_DECODE: begin
                Reg2Loc   = (cls_s == CLS_STUR) || (cls_s == CLS_CBZ) || (cls_s == CLS_CBNZ);
                illegal_s = (cls_s == CLS_ILLEGAL);
            end
            ST_MEMADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            ST_MEMREAD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            ST_MEMWB: begin
                reg_write_s = 1'b1;
                MemtoReg    = 1'b1;
            end
            ST_MEMWRITE: begin
                mem_write_s = 1'b1;
                IorD        = 1'b1;
                Reg2Loc     = 1'b1;
            end
            ST_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_RTYPE;
            end
            ST_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_IMM;
            end
            ST_ALUWB: begin
                reg_write_s = 1'b1;
            end
            ST_BRANCH: begin
                Reg2Loc = 1'b1;
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_PASSB;
                PCSrc   = 1'b1;
                if (cls_s == CLS_CBZ)       pc_write_s = Zero;
                else if (cls_s == CLS_CBNZ) pc_write_s = ~Zero;
                else                        pc_write_s = 1'b0;
            end
            ST_JUMP: begin
                pc_write_s = 1'b1;
                PCSrc      = 1'b1;
            end
            ST_ERROR: begin
                illegal_s = 1'b0;
            end
            default: begin
                illegal_s = 1'b0;
            end
        endcase
    end

    // Architectural writes are suppressed in a reset cycle so an abandoned
    // instruction leaves no side effects.
    assign RegWrite   = reg_write_s & ~reset;
    assign MemWrite   = mem_write_s & ~reset;
    assign IRWrite    = ir_write_s  & ~reset;
    assign PCWrite    = pc_write_s  & ~reset;
    assign illegal_op = illegal_s   & ~reset;
    assign mem_err    = mem_err_r;
    assign state_o    = state_r;

endmodule

// File: tb/tb_multicycle_maindec.sv
// Self-checking bench for multicycle_maindec: directed vector table, timeout
// sequence and a randomized run against an instruction-level reference model.
module tb_multicycle_maindec;

    typedef struct packed {
        logic [3:0] st;
        logic reg2loc, memtoreg, regwrite, memread, memwrite, irwrite, pcwrite, iord, alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic pcsrc, illegal_op, mem_err;
    } obs_t;

    typedef struct {
        bit         rst;
        logic [10:0] op;
        bit         zero;
        bit         rdy;
        int         inst;
        bit         chk;
        logic [3:0] st;
        logic [9:0] key;
    } vec_t;

    localparam int NI = 3;
    localparam bit HI [NI] = '{1'b1, 1'b0, 1'b1};
    localparam int TO [NI] = '{0, 0, 3};

    localparam logic [10:0] LDUR = 11'b11111000010;
    localparam logic [10:0] STUR = 11'b11111000000;
    localparam logic [10:0] CBNZ = 11'b10110101000;
    localparam logic [10:0] ADDI = 11'b10010001000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Zero = 1'b0;
    logic        mem_ready = 1'b1;
    logic [10:0] Op = 11'd0;
    obs_t        obs [NI];

    int errors = 0;
    int checks = 0;
    vec_t tv[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic r2l, m2r, rw, mr, mw, irw, pcw, iord, asa, pcs, ill, merr;
        logic [1:0] asb, aop;
        logic [3:0] st;
        multicycle_maindec #(
            .HAS_IMM(HI[g]), .MEM_HANDSHAKE(1'b1), .MEM_TIMEOUT(TO[g])
        ) u_dut (
            .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .mem_ready(mem_ready),
            .Reg2Loc(r2l), .MemtoReg(m2r), .RegWrite(rw), .MemRead(mr), .MemWrite(mw),
            .IRWrite(irw), .PCWrite(pcw), .IorD(iord), .ALUSrcA(asa), .ALUSrcB(asb),
            .ALUOp(aop), .PCSrc(pcs), .illegal_op(ill), .mem_err(merr), .state_o(st)
        );
        assign obs[g] = {st, r2l, m2r, rw, mr, mw, irw, pcw, iord, asa, asb, aop, pcs, ill, merr};
    end

    // key = {RegWrite, MemtoReg, MemWrite, PCWrite, PCSrc, IRWrite, illegal_op, mem_err, ALUOp}
    function automatic logic [9:0] key_of(input obs_t o);
        return {o.regwrite, o.memtoreg, o.memwrite, o.pcwrite, o.pcsrc,
                o.irwrite, o.illegal_op, o.mem_err, o.aluop};
    endfunction

    task automatic add(input bit rst, input logic [10:0] op, input bit z, input bit rdy,
                       input int inst, input bit chk, input logic [3:0] st, input logic [9:0] key);
        tv.push_back('{rst, op, z, rdy, inst, chk, st, key});
    endtask

    // Reference model: classes from the opcode bit patterns, written as text.
    function automatic bit pmatch(input logic [10:0] op, input string pat);
        for (int i = 0; i < 11; i++) begin
            if (pat[i] != "x" && ((pat[i] == "1") != op[10-i])) return 1'b0;
        end
        return 1'b1;
    endfunction

    // 0 illegal, 1 LDUR, 2 STUR, 3 R-type, 4 I-type, 5 CBZ, 6 CBNZ, 7 B
    function automatic int classify(input logic [10:0] op, input bit has_imm);
        if (pmatch(op, "11111000010")) return 1;
        if (pmatch(op, "11111000000")) return 2;
        if (pmatch(op, "10001011000") || pmatch(op, "11001011000") ||
            pmatch(op, "10001010000") || pmatch(op, "10101010000")) return 3;
        if (has_imm && (pmatch(op, "1001000100x") || pmatch(op, "1101000100x"))) return 4;
        if (pmatch(op, "10110100xxx")) return 5;
        if (pmatch(op, "10110101xxx")) return 6;
        if (pmatch(op, "000101xxxxx")) return 7;
        return 0;
    endfunction

    function automatic obs_t model_out(input int step, input int cls, input bit z, input bit rdy);
        obs_t e = '0;
        e.st = 4'(step);
        case (step)
            0:  begin e.memread = 1'b1; e.alusrcb = 2'b01; e.irwrite = rdy; e.pcwrite = rdy; end
            1:  begin e.reg2loc = (cls == 2 || cls == 5 || cls == 6); e.illegal_op = (cls == 0); end
            2:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            3:  begin e.memread = 1'b1; e.iord = 1'b1; end
            4:  begin e.regwrite = 1'b1; e.memtoreg = 1'b1; end
            5:  begin e.memwrite = 1'b1; e.iord = 1'b1; e.reg2loc = 1'b1; end
            6:  begin e.alusrca = 1'b1; e.aluop = 2'b10; end
            7:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; e.aluop = 2'b11; end
            8:  begin e.regwrite = 1'b1; end
            9:  begin e.reg2loc = 1'b1; e.alusrca = 1'b1; e.aluop = 2'b01; e.pcsrc = 1'b1;
                      e.pcwrite = (cls == 5) ? z : !z; end
            10: begin e.pcwrite = 1'b1; e.pcsrc = 1'b1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic logic [10:0] pick_op();
        logic [10:0] r = 11'($urandom);
        case ($urandom_range(0, 9))
            0: return 11'b11111000010;
            1: return 11'b11111000000;
            2: return {8'b10110100, r[2:0]};
            3: return {8'b10110101, r[2:0]};
            4: return {6'b000101, r[4:0]};
            5: case (r[1:0])
                   2'd0: return 11'b10001011000;
                   2'd1: return 11'b11001011000;
                   2'd2: return 11'b10001010000;
                   default: return 11'b10101010000;
               endcase
            6: return {r[10] ? 10'b1001000100 : 10'b1101000100, r[0]};
            default: return r;
        endcase
    endfunction

    task automatic step(input bit r, input bit rdy);
        @(negedge clk);
        reset = r;
        mem_ready = rdy;
        #2;
    endtask

    task automatic expect_to(input string nm, input logic [3:0] st, input logic mw, input logic me);
        checks++;
        if ({obs[2].st, obs[2].memwrite, obs[2].mem_err} !== {st, mw, me}) begin
            errors++;
            $display("FAIL %s: got state=%0d MemWrite=%b mem_err=%b, want state=%0d MemWrite=%b mem_err=%b",
                     nm, obs[2].st, obs[2].memwrite, obs[2].mem_err, st, mw, me);
        end
    endtask

    initial begin
        int   plan[$];
        int   cls;
        obs_t exp_o;

        // reset, LDUR with two not-ready cycles in MEMREAD
        add(1, LDUR, 0, 1, 0, 0, 4'd0, 10'b00_0_00_0_00_00);
        add(1, LDUR, 0, 1, 0, 1, 4'd0, 10'b00_0_00_0_00_00);
        add(0, LDUR, 0, 1, 0, 1, 4'd0, 10'b00_0_10_1_00_00);
        add(0, LDUR, 0, 1, 0, 1, 4'd1, 10'b00_0_00_0_00_00);
        add(0, LDUR, 0, 1, 0, 1, 4'd2, 10'b00_0_00_0_00_00);
        add(0, LDUR, 0, 0, 0, 1, 4'd3, 10'b00_0_00_0_00_00);
        add(0, LDUR, 0, 0, 0, 1, 4'd3, 10'b00_0_00_0_00_00);
        add(0, LDUR, 0, 1, 0, 1, 4'd3, 10'b00_0_00_0_00_00);
        add(0, LDUR, 0, 1, 0, 1, 4'd4, 10'b11_0_00_0_00_00);
        // CBNZ taken (Zero=0) then not taken (Zero=1)
        add(0, CBNZ, 0, 1, 0, 1, 4'd0, 10'b00_0_10_1_00_00);
        add(0, CBNZ, 0, 1, 0, 1, 4'd1, 10'b00_0_00_0_00_00);
        add(0, CBNZ, 0, 1, 0, 1, 4'd9, 10'b00_0_11_0_00_01);
        add(0, CBNZ, 1, 1, 0, 1, 4'd0, 10'b00_0_10_1_00_00);
        add(0, CBNZ, 1, 1, 0, 1, 4'd1, 10'b00_0_00_0_00_00);
        add(0, CBNZ, 1, 1, 0, 1, 4'd9, 10'b00_0_01_0_00_01);
        // ADDI with immediates enabled
        add(0, ADDI, 0, 1, 0, 1, 4'd0, 10'b00_0_10_1_00_00);
        add(0, ADDI, 0, 1, 0, 1, 4'd1, 10'b00_0_00_0_00_00);
        add(0, ADDI, 0, 1, 0, 1, 4'd7, 10'b00_0_00_0_00_11);
        add(0, ADDI, 0, 1, 0, 1, 4'd8, 10'b10_0_00_0_00_00);
        add(0, ADDI, 0, 1, 0, 1, 4'd0, 10'b00_0_10_1_00_00);
        // ADDI with immediates disabled: one-cycle illegal_op, back to FETCH
        add(1, ADDI, 0, 1, 1, 0, 4'd0, 10'b00_0_00_0_00_00);
        add(1, ADDI, 0, 1, 1, 1, 4'd0, 10'b00_0_00_0_00_00);
        add(0, ADDI, 0, 1, 1, 1, 4'd0, 10'b00_0_10_1_00_00);
        add(0, ADDI, 0, 1, 1, 1, 4'd1, 10'b00_0_00_0_10_00);
        add(0, ADDI, 0, 1, 1, 1, 4'd0, 10'b00_0_10_1_00_00);
        // reset arriving while in MEMWRITE with memory ready
        add(1, STUR, 0, 1, 0, 0, 4'd0, 10'b00_0_00_0_00_00);
        add(0, STUR, 0, 1, 0, 1, 4'd0, 10'b00_0_10_1_00_00);
        add(0, STUR, 0, 1, 0, 1, 4'd1, 10'b00_0_00_0_00_00);
        add(0, STUR, 0, 1, 0, 1, 4'd2, 10'b00_0_00_0_00_00);
        add(1, STUR, 0, 1, 0, 1, 4'd5, 10'b00_0_00_0_00_00);
        add(0, STUR, 0, 0, 0, 1, 4'd0, 10'b00_0_00_0_00_00);

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            reset = tv[i].rst;
            Op = tv[i].op;
            Zero = tv[i].zero;
            mem_ready = tv[i].rdy;
            #2;
            if (tv[i].chk) begin
                checks++;
                if ({obs[tv[i].inst].st, key_of(obs[tv[i].inst])} !== {tv[i].st, tv[i].key}) begin
                    errors++;
                    $display("FAIL vec%0d inst%0d: got state=%0d key=%b, want state=%0d key=%b",
                             i, tv[i].inst, obs[tv[i].inst].st, key_of(obs[tv[i].inst]),
                             tv[i].st, tv[i].key);
                end
            end
        end

        // MEM_TIMEOUT=3: ready on the limit cycle wins, then a real timeout
        Op = STUR;
        step(1, 1); step(1, 1); expect_to("to_reset", 4'd0, 1'b0, 1'b0);
        step(0, 1); expect_to("to_fetch", 4'd0, 1'b0, 1'b0);
        step(0, 1); expect_to("to_decode", 4'd1, 1'b0, 1'b0);
        step(0, 1); expect_to("to_memaddr", 4'd2, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0); expect_to("to_wait_a", 4'd5, 1'b1, 1'b0);
        end
        step(0, 1); expect_to("to_ready_at_limit", 4'd5, 1'b1, 1'b0);
        step(0, 1); expect_to("to_ready_wins", 4'd0, 1'b0, 1'b0);
        step(0, 1); expect_to("to_decode2", 4'd1, 1'b0, 1'b0);
        step(0, 1); expect_to("to_memaddr2", 4'd2, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(0, 0); expect_to("to_wait_b", 4'd5, 1'b1, 1'b0);
        end
        step(0, 0); expect_to("to_error", 4'd11, 1'b0, 1'b1);
        step(0, 1); expect_to("to_sticky1", 4'd11, 1'b0, 1'b1);
        step(0, 1); expect_to("to_sticky2", 4'd11, 1'b0, 1'b1);
        step(1, 1); expect_to("to_reset_cycle", 4'd11, 1'b0, 1'b1);
        step(0, 1); expect_to("to_cleared", 4'd0, 1'b0, 1'b0);

        // randomized run against the instruction-level model (default config)
        step(1, 1); step(1, 1);
        cls = 0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            reset = 1'b0;
            if (plan.size() == 0) begin
                Op = pick_op();
                cls = classify(Op, 1'b1);
                case (cls)
                    1: plan = '{0, 1, 2, 3, 4};
                    2: plan = '{0, 1, 2, 5};
                    3: plan = '{0, 1, 6, 8};
                    4: plan = '{0, 1, 7, 8};
                    5, 6: plan = '{0, 1, 9};
                    7: plan = '{0, 1, 10};
                    default: plan = '{0, 1};
                endcase
            end
            Zero = 1'($urandom_range(0, 1));
            mem_ready = ($urandom_range(0, 3) != 0);
            #2;
            exp_o = model_out(plan[0], cls, Zero, mem_ready);
            checks++;
            if (obs[0] !== exp_o) begin
                errors++;
                $display("FAIL rand%0d op=%b: got %h, want %h", n, Op, obs[0], exp_o);
            end
            if (!((plan[0] == 0 || plan[0] == 3 || plan[0] == 5) && !mem_ready))
                void'(plan.pop_front());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
